fp_convert_seq: RTL and testbench

Parametrised, sequential successor to the Lab 1 linear-to-floating-point converter. It takes an IN_W-bit two's-complement sample and produces sign, an EXP_W-bit exponent and a SIG_W-bit significand. It uses a serial normaliser (one shift per clock), three selectable rounding modes and saturation. A valid/ready handshake on both sides lets it sit between a sample source and the display/encoder stage of the FP_conversion datapath.

---
 rtl/fp_convert_seq.sv | 171 +++++++++++++++++
 tb/tb_fp_convert_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_convert_seq.sv
// Sequential two's-complement to sign/exponent/significand converter with a
// one-shift-per-clock normaliser, selectable rounding and saturation.
module fp_convert_seq #(
   parameter int IN_W  = 12,
   parameter int EXP_W = 3,
   parameter int SIG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  din,
   input  logic [1:0]       round_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign,
   output logic [EXP_W-1:0] exp,
   output logic [SIG_W-1:0] sig,
   output logic             ovf,
   output logic [1:0]       state_dbg
);

   localparam int MAG_W = IN_W - 1;
   localparam int LOW_W = MAG_W - SIG_W;
   localparam int EMAX  = IN_W - 1 - SIG_W;

   // Handshake: a word moves on any edge where valid && ready; in_ready only in IDLE,
   // out_valid only in DONE, and results stay stable in DONE until out_ready.
   typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

   state_t             state_q, state_d;
   logic [MAG_W-1:0]   mag_q, mag_d;
   logic [EXP_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         mode_q, mode_d;
   logic               sat_q, sat_d;
   logic               sgn_in_q, sgn_in_d;
   logic               sign_q, sign_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [SIG_W-1:0]   sig_q, sig_d;
   logic               ovf_q, ovf_d;

   logic [IN_W-1:0]    neg_din;
   logic [SIG_W-1:0]   s0;
   logic [LOW_W-1:0]   low, low_sh;
   logic               r, st, inc;
   logic [SIG_W:0]     t;
   logic               norm_done;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign norm_done = mag_q[MAG_W-1] || (cnt_q == '0);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = NORM;
         NORM:    if (norm_done) state_d = ROUND;
         ROUND:                  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == DONE);
      state_dbg = state_q;
   end

   // Rounding datapath, evaluated from the normalised magnitude
   always_comb begin
      neg_din = -din;
      s0      = mag_q[MAG_W-1 -: SIG_W];
      low     = mag_q[LOW_W-1:0];
      low_sh  = low << 1;
      r       = low[LOW_W-1];
      st      = |low_sh;
      case (mode_q)
         2'b01:   inc = 1'b0;
         2'b10:   inc = r && (st || s0[0]);
         default: inc = r;
      endcase
      t = {1'b0, s0} + {{SIG_W{1'b0}}, inc};
   end

   always_comb begin
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      sat_d    = sat_q;
      sgn_in_d = sgn_in_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      sig_d    = sig_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sgn_in_d = din[IN_W-1];
               mode_d   = round_mode;
               cnt_d    = EXP_W'(EMAX);
               // The most negative input has no positive magnitude; clamp and flag it
               sat_d    = din[IN_W-1] && (din[IN_W-2:0] == '0);
               if (sat_d)            mag_d = '1;
               else if (din[IN_W-1]) mag_d = neg_din[MAG_W-1:0];
               else                  mag_d = din[MAG_W-1:0];
            end
         end
         NORM: begin
            if (!norm_done) begin
               mag_d = mag_q << 1;
               cnt_d = cnt_q - 1'b1;
            end
         end
         ROUND: begin
            sign_d = sgn_in_q;
            ovf_d  = sat_q;
            if (t[SIG_W]) begin
               if (cnt_q == '1) begin
                  exp_d = '1;
                  sig_d = '1;
                  ovf_d = 1'b1;
               end else begin
                  exp_d = cnt_q + 1'b1;
                  sig_d = {1'b1, {(SIG_W-1){1'b0}}};
               end
            end else begin
               exp_d = cnt_q;
               sig_d = t[SIG_W-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_q    <= '0;
         cnt_q    <= '0;
         mode_q   <= '0;
         sat_q    <= 1'b0;
         sgn_in_q <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         sig_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         sat_q    <= sat_d;
         sgn_in_q <= sgn_in_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         sig_q    <= sig_d;
         ovf_q    <= ovf_d;
      end
   end

   assign sign = sign_q;
   assign exp  = exp_q;
   assign sig  = sig_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_fp_convert_seq.sv
// Directed bench for fp_convert_seq: vector table with hand-computed results,
// plus backpressure and mid-conversion reset sequences.
module tb_fp_convert_seq;

   localparam int IN_W  = 12;
   localparam int EXP_W = 3;
   localparam int SIG_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  din;
   logic [1:0]       round_mode;
   logic             out_valid;
   logic             out_ready;
   logic             sign;
   logic [EXP_W-1:0] exp;
   logic [SIG_W-1:0] sig;
   logic             ovf;
   logic [1:0]       state_dbg;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   fp_convert_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .round_mode(round_mode), .out_valid(out_valid),
      .out_ready(out_ready), .sign(sign), .exp(exp), .sig(sig), .ovf(ovf),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [IN_W-1:0]  din;
      logic [1:0]       mode;
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
      logic             ovf;
      int               lat;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input int act, input int req);
      tot_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   task automatic chk_result(input string name, input vec_t v);
      chk({name, " sign"}, sign, v.sign);
      chk({name, " exp"},  exp,  v.exp);
      chk({name, " sig"},  sig,  v.sig);
      chk({name, " ovf"},  ovf,  v.ovf);
   endtask

   // Accept at the next posedge; returns edges counted until out_valid is seen.
   task automatic accept_and_wait(input logic [IN_W-1:0] d, input logic [1:0] m,
                                  output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) chk("in_ready timeout", 0, 1);
      in_valid   = 1'b1;
      din        = d;
      round_mode = m;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      // A late mode change must not affect the conversion in flight
      round_mode = (m == 2'b01) ? 2'b00 : 2'b01;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) break;
      end
      if (!out_valid) chk("out_valid timeout", 0, 1);
   endtask

   initial begin
      int lat;
      logic [EXP_W-1:0] hold_exp;
      logic [SIG_W-1:0] hold_sig;

      //           din      mode  sign exp  sig  ovf lat
      vecs[0]  = '{12'd125,  2'b00, 0, 3'd4, 4'd8,  0, 6};
      vecs[1]  = '{12'd2047, 2'b00, 0, 3'd7, 4'd15, 1, 2};
      vecs[2]  = '{12'd2047, 2'b01, 0, 3'd7, 4'd15, 0, 2};
      vecs[3]  = '{12'h800,  2'b00, 1, 3'd7, 4'd15, 1, 2};
      vecs[4]  = '{12'hFFF,  2'b00, 1, 3'd0, 4'd1,  0, 9};
      vecs[5]  = '{12'd0,    2'b00, 0, 3'd0, 4'd0,  0, 9};
      vecs[6]  = '{12'd42,   2'b00, 0, 3'd2, 4'd11, 0, 7};
      vecs[7]  = '{12'd42,   2'b01, 0, 3'd2, 4'd10, 0, 7};
      vecs[8]  = '{12'd42,   2'b10, 0, 3'd2, 4'd10, 0, 7};
      vecs[9]  = '{12'd43,   2'b10, 0, 3'd2, 4'd11, 0, 7};
      vecs[10] = '{12'd42,   2'b11, 0, 3'd2, 4'd11, 0, 7};
      vecs[11] = '{12'd46,   2'b10, 0, 3'd2, 4'd12, 0, 7};
      vecs[12] = '{12'd1000, 2'b10, 0, 3'd7, 4'd8,  0, 3};
      vecs[13] = '{12'd120,  2'b10, 0, 3'd3, 4'd15, 0, 6};
      vecs[14] = '{12'hF83,  2'b00, 1, 3'd4, 4'd8,  0, 6};

      rst        = 1'b1;
      in_valid   = 1'b0;
      din        = '0;
      round_mode = 2'b00;
      out_ready  = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready",  in_ready,  0);
      chk("reset out_valid", out_valid, 0);
      chk("reset exp",       exp,       0);
      chk("reset sig",       sig,       0);
      chk("reset ovf",       ovf,       0);
      chk("reset sign",      sign,      0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready after release", in_ready, 1);

      foreach (vecs[i]) begin
         accept_and_wait(vecs[i].din, vecs[i].mode, lat);
         chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         chk_result($sformatf("vec%0d", i), vecs[i]);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid drop", i), out_valid, 0);
         chk($sformatf("vec%0d in_ready back", i), in_ready, 1);
      end

      // Backpressure: result held, second sample waits for the transfer
      out_ready = 1'b0;
      accept_and_wait(12'd125, 2'b00, lat);
      chk("bp latency", lat, 6);
      hold_exp = exp;
      hold_sig = sig;
      in_valid = 1'b1;
      din      = 12'd42;
      round_mode = 2'b00;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("bp out_valid held", out_valid, 1);
         chk("bp in_ready low",   in_ready,  0);
         chk("bp exp stable",     exp,       hold_exp);
         chk("bp sig stable",     sig,       hold_sig);
      end
      chk_result("bp first", vecs[0]);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp transfer out_valid", out_valid, 0);
      chk("bp in_ready after transfer", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp second accepted", in_ready, 0);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) break;
      end
      chk("bp second latency", lat, 7);
      chk_result("bp second", vecs[6]);
      @(posedge clk);
      #1;

      // Reset in the middle of normalisation of din=1
      @(negedge clk);
      in_valid = 1'b1;
      din      = 12'd1;
      round_mode = 2'b00;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid state is NORM", state_dbg, 1);
      rst = 1'b1;
      #1;
      chk("mid rst out_valid", out_valid, 0);
      chk("mid rst in_ready",  in_ready,  0);
      chk("mid rst exp",       exp,       0);
      chk("mid rst sig",       sig,       0);
      chk("mid rst sign",      sign,      0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid rst in_ready after release", in_ready, 1);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) chk("no pulse after reset", out_valid, 0);
      end
      chk("idle after reset", state_dbg, 0);
      accept_and_wait(12'd125, 2'b00, lat);
      chk("post rst latency", lat, 6);
      chk_result("post rst", vecs[0]);
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
